prach_hb1_burst_buf: RTL and testbench

//  Downstream of the HB1 half-band decimator. Takes its TDM output (one sample/clk, channels
//  0..NUM_CHANNEL-1 round-robin, sync on chn 0) into a ping-pong RAM. Re-emits each full block
//  as per-channel bursts of BURST_LEN consecutive samples on a valid/ready stream (FFT/correlator feed).

---
 rtl/prach_hb1_burst_buf.sv | 259 +++++++++++++++++++++++++
 tb/tb_prach_hb1_burst_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_hb1_burst_buf.sv
// prach_hb1_burst_buf
// Collects the HB1 decimator TDM stream (one sample per clock, channels
// round-robin, sync on channel 0) into a two-bank RAM and replays every
// completed bank as per-channel bursts of BURST_LEN samples on a
// valid/ready stream.
//
// Stream handshake: a beat transfers on a rising clk edge where
// m_valid && m_ready. Once m_valid is high it stays high, and
// m_data/m_chn/m_last stay constant, until that transfer happens.
//
// The reader takes a new bank as soon as it has issued the last RAM read
// of the current one. The last few beats are then still in the
// prefetch/skid pipeline, so consecutive banks stream back-to-back with
// m_ready=1. A bank that completes while the reader is still issuing
// reads is dropped and flagged in overflow.
module prach_hb1_burst_buf #(
  parameter int NUM_CHANNEL = 16,
  parameter int BURST_LEN   = 8,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_dq,
  input  logic [7:0]        din_chn,
  input  logic              sync_in,
  output logic [DATA_W-1:0] m_data,
  output logic [7:0]        m_chn,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              overflow,
  output logic              sync_err,
  output logic              dbg_wr_state,
  output logic              dbg_rd_state
);

  localparam int CHN_W  = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam int K_W    = $clog2(BURST_LEN);
  localparam int IDX_W  = CHN_W + K_W;
  localparam int ADDR_W = IDX_W + 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [7:0]       NC8       = 8'(NUM_CHANNEL);
  localparam logic [7:0]       LAST_CHN8 = 8'(NUM_CHANNEL - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(BURST_LEN - 1);
  localparam logic [CHN_W-1:0] CHN_LAST  = CHN_W'(NUM_CHANNEL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = {CHN_LAST, K_LAST};

  typedef enum logic {WR_WAIT_SYNC = 1'b0, WR_FILL = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_t;

  // ---------------------------------------------------------------------
  // Writer
  // ---------------------------------------------------------------------
  wr_state_t          wr_state_q, wr_state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [K_W-1:0]     wr_k_q, wr_k_d;
  logic [K_W-1:0]     k_eff;
  logic               chn_ok, start, wr_en, bank_done;
  logic [ADDR_W-1:0]  wr_addr;
  logic               handoff, ovf_set, serr_set;
  logic               overflow_q, sync_err_q;

  // Reader signals used by the writer's handoff decision
  rd_state_t          rd_state_q, rd_state_d;
  logic               rd_issue, rd_last_issue;

  assign chn_ok   = (din_chn < NC8);
  assign start    = sync_in && (din_chn == 8'd0);
  assign serr_set = sync_in && (din_chn != 8'd0);
  assign wr_addr  = {wr_bank_q, din_chn[CHN_W-1:0], k_eff};

  // Writer state register
  always_ff @(posedge clk) begin
    if (!rst_n) wr_state_q <= WR_WAIT_SYNC;
    else        wr_state_q <= wr_state_d;
  end

  // Writer next state: leave WAIT_SYNC on the first channel-0 sync
  always_comb begin
    wr_state_d = wr_state_q;
    if ((wr_state_q == WR_WAIT_SYNC) && start) wr_state_d = WR_FILL;
  end

  // Writer outputs: RAM write, burst index update, bank-complete strobe
  always_comb begin
    wr_en     = 1'b0;
    bank_done = 1'b0;
    wr_k_d    = wr_k_q;
    // a channel-0 sync always restarts the bank at k=0
    k_eff     = start ? '0 : wr_k_q;
    if (((wr_state_q == WR_FILL) || start) && chn_ok) begin
      wr_en  = 1'b1;
      wr_k_d = k_eff;
      if (din_chn == LAST_CHN8) begin
        if (k_eff == K_LAST) begin
          bank_done = 1'b1;
          wr_k_d    = '0;
        end else begin
          wr_k_d = k_eff + K_W'(1);
        end
      end
    end
  end

  assign handoff   = bank_done && ((rd_state_q == RD_IDLE) || rd_last_issue);
  assign ovf_set   = bank_done && !handoff;
  assign wr_bank_d = handoff ? ~wr_bank_q : wr_bank_q;

  // Writer datapath registers and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      wr_k_q     <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_k_q     <= wr_k_d;
      overflow_q <= overflow_q | ovf_set;
      sync_err_q <= sync_err_q | serr_set;
    end
  end

  // ---------------------------------------------------------------------
  // Reader: read issue, prefetch stage, skid and output registers
  // ---------------------------------------------------------------------
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0]  rd_addr;
  logic [1:0]         occ, occ_left;
  logic               pop, out_free;

  logic [DATA_W-1:0]  rd_data_q;
  logic               p_v_q, p_last_q;
  logic [CHN_W-1:0]   p_chn_q;
  logic               skid_v_q, skid_last_q;
  logic [CHN_W-1:0]   skid_chn_q;
  logic [DATA_W-1:0]  skid_data_q;
  logic               m_valid_q, m_last_q;
  logic [7:0]         m_chn_q;
  logic [DATA_W-1:0]  m_data_q;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  assign rd_addr  = {rd_bank_q, rd_idx_q};
  assign pop      = m_valid_q && m_ready;
  assign out_free = !m_valid_q || pop;
  // beats held in out/skid/prefetch; a read may start only if its data
  // will find a free slot when it leaves the RAM
  assign occ      = {1'b0, m_valid_q} + {1'b0, skid_v_q} + {1'b0, p_v_q};
  assign occ_left = occ - {1'b0, pop};

  // Reader state register
  always_ff @(posedge clk) begin
    if (!rst_n) rd_state_q <= RD_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  // Reader next state: a handoff wins over finishing the current bank
  always_comb begin
    rd_state_d = rd_state_q;
    if (handoff)            rd_state_d = RD_READ;
    else if (rd_last_issue) rd_state_d = RD_IDLE;
  end

  // Reader outputs: read strobe and bank/index pointer update
  always_comb begin
    rd_issue      = (rd_state_q == RD_READ) && (occ_left <= 2'd1);
    rd_last_issue = rd_issue && (rd_idx_q == IDX_LAST);
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    if (handoff) begin
      rd_bank_d = wr_bank_q;
      rd_idx_d  = '0;
    end else if (rd_issue) begin
      rd_idx_d  = rd_idx_q + IDX_W'(1);
    end
  end

  // Reader pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // Two-bank sample RAM with a registered read port
  always_ff @(posedge clk) begin
    if (wr_en)    mem_q[wr_addr] <= din_dq;
    if (rd_issue) rd_data_q      <= mem_q[rd_addr];
  end

  // Prefetch stage tags travelling alongside the RAM read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_v_q    <= 1'b0;
      p_chn_q  <= '0;
      p_last_q <= 1'b0;
    end else begin
      p_v_q <= rd_issue;
      if (rd_issue) begin
        p_chn_q  <= rd_idx_q[IDX_W-1:K_W];
        p_last_q <= (rd_idx_q[K_W-1:0] == K_LAST);
      end
    end
  end

  // Output register fed from skid first, then from the prefetch stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_chn_q     <= '0;
      m_last_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_chn_q  <= '0;
      skid_last_q <= 1'b0;
    end else if (out_free) begin
      if (skid_v_q) begin
        m_valid_q   <= 1'b1;
        m_data_q    <= skid_data_q;
        m_chn_q     <= 8'(skid_chn_q);
        m_last_q    <= skid_last_q;
        skid_v_q    <= p_v_q;
        skid_data_q <= rd_data_q;
        skid_chn_q  <= p_chn_q;
        skid_last_q <= p_last_q;
      end else if (p_v_q) begin
        m_valid_q <= 1'b1;
        m_data_q  <= rd_data_q;
        m_chn_q   <= 8'(p_chn_q);
        m_last_q  <= p_last_q;
      end else begin
        m_valid_q <= 1'b0;
      end
    end else if (p_v_q) begin
      skid_v_q    <= 1'b1;
      skid_data_q <= rd_data_q;
      skid_chn_q  <= p_chn_q;
      skid_last_q <= p_last_q;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_chn        = m_chn_q;
  assign m_last       = m_last_q;
  assign overflow     = overflow_q;
  assign sync_err     = sync_err_q;
  assign dbg_wr_state = (wr_state_q == WR_FILL);
  assign dbg_rd_state = (rd_state_q == RD_READ);

endmodule

// File: tb/tb_prach_hb1_burst_buf.sv
// Directed bench for prach_hb1_burst_buf: TDM stimulus with
// din_dq = {frame, chn}, expected bursts held in a queue.
module tb_prach_hb1_burst_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din_dq = '0;
  logic [7:0]  din_chn = 8'hFF;
  logic        sync_in = 1'b0;
  logic [15:0] m_data;
  logic [7:0]  m_chn;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic        overflow, sync_err;
  logic        dbg_wr_state, dbg_rd_state;

  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];

  int cyc_cnt = 0;
  int beats = 0;
  int first_beat_cyc = -1;
  int last_beat_cyc = -1;
  int first_valid_cyc = -1;
  int wr_edge = -1;
  int frame = 0;
  int rst_beat = -1;
  int err_sync_frame = -1;
  int stalls = 0;
  bit toggle = 1'b0;
  bit hold_v = 1'b0;
  bit rst_done = 1'b0;
  logic [24:0] hold_beat = '0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  prach_hb1_burst_buf #(.NUM_CHANNEL(16), .BURST_LEN(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_chn(din_chn), .sync_in(sync_in),
    .m_data(m_data), .m_chn(m_chn), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .overflow(overflow), .sync_err(sync_err),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // expected beats of one bank whose k=0 frame is f0: {chn, frame, chn, last}
  task automatic expect_bank(input int f0);
    logic [7:0] cc, ff;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 8; k++) begin
        cc = 8'(c);
        ff = 8'(f0 + k);
        exp_q.push_back({cc, ff, cc, (k == 7)});
      end
    end
  endtask

  // one clock: sample outputs, choose m_ready, score accepted beats
  task automatic cyc();
    logic [24:0] beat, e;
    @(posedge clk);
    cyc_cnt++;
    #1;
    beat = {m_chn, m_data, m_last};
    if (hold_v) begin
      chk("stall_valid_held", 32'(m_valid), 32'd1);
      chk("stall_beat_held", 32'(beat), 32'(hold_beat));
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
    m_ready = toggle ? ~m_ready : 1'b1;
    if (m_valid && m_ready) begin
      if (beats == 0) first_beat_cyc = cyc_cnt;
      last_beat_cyc = cyc_cnt;
      beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'(beat), 32'(e));
      end
    end
    hold_v = m_valid && !m_ready;
    if (hold_v) stalls++;
    hold_beat = beat;
    if (rst_beat >= 0 && beats == rst_beat) begin
      rst_beat = -1;
      rst_n = 1'b0;
      hold_v = 1'b0;
      @(posedge clk);
      cyc_cnt++;
      #1;
      chk("mid_reset_valid", 32'(m_valid), 32'd0);
      chk("mid_reset_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      rst_done = 1'b1;
    end
  endtask

  // driver: n full TDM frames, optional channel-0 sync on the first
  task automatic drive_frames(input int n, input bit sync_first);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 16; c++) begin
        din_chn = 8'(c);
        din_dq  = {8'(frame), 8'(c)};
        sync_in = (sync_first && f == 0 && c == 0) || (frame == err_sync_frame && c == 5);
        if (frame == 7 && c == 15 && wr_edge < 0) wr_edge = cyc_cnt + 1;
        cyc();
      end
      frame++;
    end
  endtask

  task automatic idle(input int n);
    din_chn = 8'hFF;
    din_dq  = '0;
    sync_in = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    din_chn = 8'hFF;
    din_dq  = '0;
    sync_in = 1'b0;
    while ((exp_q.size() != 0 || m_valid) && n < max_cyc) begin
      cyc();
      n++;
    end
    chk("drain_in_time", 32'(n < max_cyc), 32'd1);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    din_chn = 8'hFF;
    din_dq  = '0;
    sync_in = 1'b0;
    toggle  = 1'b0;
    m_ready = 1'b1;
    hold_v  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_last", 32'(m_last), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_m_chn", 32'(m_chn), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_sync_err", 32'(sync_err), 32'd0);
    chk("reset_wr_state", 32'(dbg_wr_state), 32'd0);
    chk("reset_rd_state", 32'(dbg_rd_state), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    frame = 0;
    beats = 0;
    stalls = 0;
    first_beat_cyc = -1;
    last_beat_cyc = -1;
    first_valid_cyc = -1;
    wr_edge = -1;
    err_sync_frame = -1;
  endtask

  initial begin
    // tests 1+2: first bank latency, then four banks streamed back-to-back
    do_reset();
    expect_bank(0);
    expect_bank(8);
    expect_bank(16);
    expect_bank(24);
    drive_frames(32, 1'b1);
    drain(400);
    chk("t1_first_beat_latency", 32'(first_valid_cyc), 32'(wr_edge + 2));
    chk("t2_beat_count", 32'(beats), 32'd512);
    chk("t2_no_gaps", 32'(last_beat_cyc - first_beat_cyc + 1), 32'd512);
    chk("t2_overflow", 32'(overflow), 32'd0);
    chk("t2_sync_err", 32'(sync_err), 32'd0);

    // test 3: stalled drain of bank 0 drops bank 1, bank 2 intact
    do_reset();
    expect_bank(0);
    expect_bank(16);
    drive_frames(8, 1'b1);
    toggle = 1'b1;
    drive_frames(4, 1'b0);
    toggle = 1'b0;
    drive_frames(3, 1'b0);
    chk("t3_overflow_before_drop", 32'(overflow), 32'd0);
    drive_frames(1, 1'b0);
    chk("t3_overflow_at_drop", 32'(overflow), 32'd1);
    drive_frames(8, 1'b0);
    drain(400);
    chk("t3_stalls_seen", 32'(stalls > 0), 32'd1);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // test 4: sync on channel 5 flags an error but leaves data alone
    do_reset();
    expect_bank(0);
    err_sync_frame = 2;
    drive_frames(8, 1'b1);
    err_sync_frame = -1;
    drain(300);
    chk("t4_sync_err", 32'(sync_err), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd0);

    // test 5: re-sync at k=3 restarts the bank with frame 3 as k=0
    do_reset();
    expect_bank(3);
    drive_frames(3, 1'b1);
    drive_frames(8, 1'b1);
    drain(300);
    chk("t5_sync_err", 32'(sync_err), 32'd0);
    chk("t5_beat_count", 32'(beats), 32'd128);

    // test 6: reset at beat 40, input ignored until the next sync
    do_reset();
    expect_bank(0);
    rst_done = 1'b0;
    rst_beat = 40;
    drive_frames(16, 1'b1);
    chk("t6_reset_applied", 32'(rst_done), 32'd1);
    idle(20);
    chk("t6_quiet_after_reset", 32'(m_valid), 32'd0);
    expect_bank(16);
    drive_frames(8, 1'b1);
    drain(300);
    chk("t6_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
